// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
// Shared definitions for the bit-serial adder: the FSM state encoding and the
// default operand width.
// -----------------------------------------------------------------------------
package serial_adder_pkg;

   // Default operand / sum width in bits.
   localparam int SA_DEFAULT_N = 3;

   // Controller states.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage : serial_adder_pkg

// File: rtl/serial_adder_full_add.sv
// -----------------------------------------------------------------------------
// full_add
// One-bit combinational full adder used as the single arithmetic element of the
// bit-serial adder.
//
// Ports:
//   a, b  : operand bits
//   ci    : carry in
//   s     : sum bit   (a ^ b ^ ci)
//   c     : carry out ((a & b) | (ci & (a | b)))
// -----------------------------------------------------------------------------
module full_add (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic c
);

   assign s = a ^ b ^ ci;
   assign c = (a & b) | (ci & (a | b));

endmodule : full_add

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
// Bit-serial adder: computes A + B + CI one bit per clock, LSB first, through a
// single full adder. An accepted start latches the operands; N cycles later a
// one-cycle done pulse accompanies the registered sum, carry-out and signed
// overflow flag. Back-to-back operations are possible by holding start high.
//
// Ports:
//   clk   : clock, all state changes on the rising edge
//   rst   : asynchronous active-high reset
//   start : request to begin an addition (honoured in IDLE or DONE only)
//   A, B  : N-bit operands, sampled on an accepted start
//   CI    : carry in, sampled on an accepted start
//   busy  : high while bits are being processed (RUN)
//   done  : one-cycle result-valid pulse (DONE)
//   S     : registered sum, A + B + CI mod 2^N
//   CO    : unsigned carry out
//   OVF   : two's-complement overflow
// -----------------------------------------------------------------------------
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int N = SA_DEFAULT_N
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   input  logic         CI,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] S,
   output logic         CO,
   output logic         OVF
);

   localparam int              CNT_W    = (N > 1) ? $clog2(N) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(N - 1);

   state_t           state_q, state_d;
   logic [N-1:0]     a_sh_q, a_sh_d;
   logic [N-1:0]     b_sh_q, b_sh_d;
   logic [N-1:0]     sum_sh_q, sum_sh_d;
   logic [N-1:0]     s_q, s_d;
   logic             carry_q, carry_d;
   logic             co_q, co_d;
   logic             ovf_q, ovf_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             fa_s, fa_c;
   logic             accept;
   logic             last_bit;

   full_add u_full_add (
      .a  (a_sh_q[0]),
      .b  (b_sh_q[0]),
      .ci (carry_q),
      .s  (fa_s),
      .c  (fa_c)
   );

   // start is only honoured when no addition is in flight.
   assign accept   = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
   assign last_bit = (cnt_q == LAST_BIT);

   // ---------------------------------------------------------------- state reg
   // NOTE: sequential state uses non-blocking (<=) so every flop samples the
   // pre-edge values of the others; blocking here would create order races.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // --------------------------------------------------------------- next state
   // NOTE: every combinational output gets a default before the case so no
   // path leaves it unassigned, which would infer a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start)    state_d = ST_RUN;
         ST_RUN:  if (last_bit) state_d = ST_DONE;
         ST_DONE: state_d = start ? ST_RUN : ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // ------------------------------------------------------------- FSM outputs
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state_q)
         ST_RUN:  busy = 1'b1;
         ST_DONE: done = 1'b1;
         default: ;
      endcase
   end

   // ------------------------------------------------------------- datapath
   always_comb begin
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      sum_sh_d = sum_sh_q;
      carry_d  = carry_q;
      cnt_d    = cnt_q;
      s_d      = s_q;
      co_d     = co_q;
      ovf_d    = ovf_q;

      if (accept) begin
         a_sh_d   = A;
         b_sh_d   = B;
         carry_d  = CI;
         cnt_d    = '0;
         sum_sh_d = '0;
      end else if (state_q == ST_RUN) begin
         a_sh_d   = {1'b0, a_sh_q[N-1:1]};
         b_sh_d   = {1'b0, b_sh_q[N-1:1]};
         // Sum bits enter at the MSB so bit i settles in position i after N shifts.
         sum_sh_d = {fa_s, sum_sh_q[N-1:1]};
         carry_d  = fa_c;
         cnt_d    = cnt_q + 1'b1;
         if (last_bit) begin
            s_d   = {fa_s, sum_sh_q[N-1:1]};
            co_d  = fa_c;
            // carry_q is the carry into the MSB while the MSB is processed.
            ovf_d = carry_q ^ fa_c;
         end
      end
   end

   // NOTE: these registers are a handful of flops, not a memory array, so all
   // of them are cleared by reset and an aborted operation leaves no residue.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         sum_sh_q <= '0;
         carry_q  <= 1'b0;
         cnt_q    <= '0;
         s_q      <= '0;
         co_q     <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         sum_sh_q <= sum_sh_d;
         carry_q  <= carry_d;
         cnt_q    <= cnt_d;
         s_q      <= s_d;
         co_q     <= co_d;
         ovf_q    <= ovf_d;
      end
   end

   assign S   = s_q;
   assign CO  = co_q;
   assign OVF = ovf_q;

endmodule : serial_adder

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter N, default 3, meaning operand and sum width in bits (N >= 2).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes occur on its rising edge.
REQ-003 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-004 SHALL have port start, input, 1, meaning request to begin an addition.
REQ-005 SHALL have port A, input, N, meaning operand A, sampled only when start is accepted.
REQ-006 SHALL have port B, input, N, meaning operand B, sampled only when start is accepted.
REQ-007 SHALL have port CI, input, 1, meaning carry-in, sampled only when start is accepted.
REQ-008 SHALL have port busy, output, 1, high while bits are being processed.
REQ-009 SHALL have port done, output, 1, a one-cycle result-valid pulse.
REQ-010 SHALL have port S, output, N, meaning registered sum A+B+CI mod 2^N.
REQ-011 SHALL have port CO, output, 1, meaning unsigned carry-out.
REQ-012 SHALL have port OVF, output, 1, meaning two's-complement overflow of A+B+CI.

Function
REQ-013 SHALL implement states IDLE, RUN and DONE.
REQ-014 SHALL accept start only in IDLE or DONE; start in RUN SHALL be ignored with no effect.
REQ-015 On an accepted start, SHALL latch A, B and CI into internal shift registers and the carry register, clear the bit counter, and enter RUN.
REQ-016 In RUN, SHALL process one bit per cycle, LSB first, through a single one-bit full adder: sum bit = a^b^c, carry = (a&b)|(c&(a|b)).
REQ-017 SHALL shift each sum bit into a result shift register MSB-side, so that S[i] holds bit i after N RUN cycles.
REQ-018 SHALL leave RUN after exactly N cycles, entering DONE at the edge that processes bit N-1.
REQ-019 SHALL update S, CO (final carry) and OVF (carry into MSB XOR carry out of MSB) only on entry to DONE, and SHALL hold them at all other times.
REQ-020 SHALL drive busy = 1 exactly while in RUN.
REQ-021 SHALL drive done = 1 exactly while in DONE, which lasts one cycle.
REQ-022 Latency: if start is accepted at edge E0, done SHALL be high in the cycle following edge EN.
REQ-023 DONE SHALL go to RUN if start is high, and to IDLE otherwise, allowing back-to-back operations with no idle gap.
REQ-024 A, B and CI changing during RUN SHALL NOT affect the result in progress.

Reset
REQ-025 rst high SHALL immediately force state IDLE, busy=0, done=0, S=0, CO=0 and OVF=0, and SHALL clear the shift registers, carry and counter.
REQ-026 Reset during RUN SHALL abort the operation; no done pulse is produced for it.
REQ-027 After rst deasserts, the first rising edge with start=1 SHALL be accepted.

Structure
REQ-028 SHALL place the state encoding (IDLE/RUN/DONE) and the default width constant in package serial_adder_pkg.
REQ-029 SHALL instantiate a one-bit combinational sub-module full_add (inputs a, b, ci; outputs s, c).
REQ-030 SHALL size the bit counter to $clog2(N) bits minimum.

Verification (N=3)
REQ-031 SHALL cover: A=6, B=1, CI=1, start -> after 3 busy cycles, done pulse, S=0, CO=1, OVF=0.
REQ-032 SHALL cover: A=3, B=3, CI=0 -> S=6, CO=0, OVF=1; then A=7, B=7, CI=1 -> S=7, CO=1, OVF=0.
REQ-033 SHALL cover: start held high continuously -> done every 4th cycle and busy low only during done cycles; results 5+3+0 -> S=0, CO=1, OVF=0.
REQ-034 SHALL cover: start re-pulsed and A/B changed mid-RUN -> ignored; the original result is delivered unchanged.
REQ-035 SHALL cover: rst asserted in the 2nd RUN cycle -> outputs immediately 0, no done pulse; the next start (4+6+0) -> S=2, CO=1, OVF=1.
